// File: rtl/pwm_pkg.sv
// Shared constants, state type and level decoder for the PWM capture block.
package pwm_pkg;

  localparam int unsigned PWM_PERIOD = 256;
  localparam int unsigned PWM_STEP   = 17;
  localparam int unsigned HEX_W      = 4;
  localparam int unsigned HEX_MAX    = 15;

  typedef enum logic [1:0] {S_SYNC, S_HIGH, S_LOW} cap_state_t;

  // Recovered level = number of thresholds 17k-8 (k = 1..15) reached by the high time.
  function automatic logic [HEX_W-1:0] duty_to_hex(input logic [15:0] h);
    logic [HEX_W-1:0] lvl;
    lvl = '0;
    for (int unsigned k = 1; k <= HEX_MAX; k++) begin
      if (h >= 16'(PWM_STEP * k - PWM_STEP / 2)) lvl = lvl + HEX_W'(1);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// PWM line in, recovered level and status out.
interface pwm_capture_if;
  import pwm_pkg::*;

  logic             pwm_in;
  logic [HEX_W-1:0] hex_out;
  logic             valid;
  logic             locked;
  logic             period_err;

  modport master (output pwm_in, input hex_out, valid, locked, period_err);
  modport slave  (input pwm_in, output hex_out, valid, locked, period_err);
endinterface

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM line and flags its rising/falling edges.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic pwm_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;
  logic                   fall_q;

  // Edge flags come from the last two taps, so they align with pwm_s versus pwm_s one cycle back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
      fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM line and recovers the 4-bit level behind it.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD      = PWM_PERIOD,
  parameter int unsigned PERIOD_TOL  = 2,
  parameter int unsigned TIMEOUT     = 512,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  pwm_capture_if.slave cap
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned      P_W       = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [P_W-1:0]   P_MIN     = P_W'(PERIOD - PERIOD_TOL);
  localparam logic [P_W-1:0]   P_MAX     = P_W'(PERIOD + PERIOD_TOL);

  logic             pwm_s, rise, fall, any_edge;
  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d, low_q, low_d, idle_q, idle_d;
  logic [HEX_W-1:0] hex_q, hex_d;
  logic             valid_q, valid_d, locked_q, locked_d, err_q, err_d;
  logic [P_W-1:0]   period_c;
  logic             period_ok;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_i  (cap.pwm_in),
    .pwm_s_o(pwm_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign any_edge  = rise | fall;
  assign period_c  = P_W'(high_q) + P_W'(low_q);
  assign period_ok = (period_c >= P_MIN) && (period_c <= P_MAX);

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_SYNC;
      high_q   <= '0;
      low_q    <= '0;
      idle_q   <= '0;
      hex_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      high_q   <= high_d;
      low_q    <= low_d;
      idle_q   <= idle_d;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // Measurement FSM; a stuck-line timeout overrides it, but any edge suppresses the timeout.
  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    low_d    = low_q;
    idle_d   = idle_q;
    hex_d    = hex_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;

    if (any_edge) begin
      idle_d = '0;
    end else if (idle_q != CNT_MAX) begin
      idle_d = idle_q + CNT_W'(1);
    end

    case (state_q)
      S_SYNC: begin
        if (rise) begin
          high_d  = CNT_W'(1);
          low_d   = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          low_d   = CNT_W'(1);
          state_d = S_LOW;
        end else if (pwm_s && high_q != CNT_MAX) begin
          high_d = high_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (rise) begin
          if (period_ok) begin
            hex_d    = duty_to_hex(16'(high_q));
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
          high_d  = CNT_W'(1);
          low_d   = '0;
          state_d = S_HIGH;
        end else if (!pwm_s && low_q != CNT_MAX) begin
          low_d = low_q + CNT_W'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (!any_edge && idle_q == IDLE_LAST) begin
      hex_d    = pwm_s ? HEX_W'(HEX_MAX) : '0;
      valid_d  = 1'b1;
      locked_d = 1'b0;
      state_d  = S_SYNC;
    end
  end

  assign cap.hex_out    = hex_q;
  assign cap.valid      = valid_q;
  assign cap.locked     = locked_q;
  assign cap.period_err = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: pulse trains checked cycle by cycle against an edge-timestamp model.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int TIMEOUT = 512;
  localparam int TOL     = 2;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 1;  // value driven at negedge c shows its result at negedge c+LAT

  typedef struct {
    int         at;
    bit         err;
    bit         lock;
    logic [3:0] hex;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_capture_if bus ();

  pwm_capture #(
    .PERIOD     (256),
    .PERIOD_TOL (TOL),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cap(bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  ev_t        evq[$];
  int         cyc, last_edge, last_rise, last_fall;
  bit         lvl, have_rise, have_fall, fired;
  bit         m_valid, m_err, m_locked;
  logic [3:0] m_hex;

  // Level from high time: H/17 rounded to nearest, clipped at 15.
  function automatic logic [3:0] ref_hex(input int h);
    int r;
    r = (h + 8) / 17;
    if (r > 15) r = 15;
    return 4'(r);
  endfunction

  // One cycle: expose the model's outputs for this sample, then drive v and update the model.
  task automatic step(input bit v);
    ev_t e;
    int  p, h;
    @(negedge clk);
    m_valid = 1'b0;
    m_err   = 1'b0;
    while (evq.size() > 0 && evq[0].at == cyc) begin
      e = evq.pop_front();
      if (e.err) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_valid  = 1'b1;
        m_hex    = e.hex;
        m_locked = e.lock;
      end
    end
    bus.pwm_in = v;
    if (v != lvl) begin
      if (v) begin
        if (have_rise && have_fall) begin
          p = cyc - last_rise;
          h = last_fall - last_rise;
          if (p >= 256 - TOL && p <= 256 + TOL) evq.push_back('{cyc + LAT, 1'b0, 1'b1, ref_hex(h)});
          else evq.push_back('{cyc + LAT, 1'b1, 1'b0, 4'h0});
        end
        have_rise = 1'b1;
        have_fall = 1'b0;
        last_rise = cyc;
      end else if (have_rise) begin
        have_fall = 1'b1;
        last_fall = cyc;
      end
      last_edge = cyc;
      fired     = 1'b0;
    end else if (!fired && cyc - last_edge == TIMEOUT) begin
      evq.push_back('{cyc + LAT, 1'b0, 1'b0, v ? 4'hF : 4'h0});
      fired     = 1'b1;
      have_rise = 1'b0;
    end
    lvl = v;
    cyc++;
  endtask

  // Clears the model while rst is low, then releases it; idle time counts from the release.
  task automatic finish_reset();
    evq.delete();
    lvl = 1'b0; have_rise = 1'b0; have_fall = 1'b0; fired = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; m_locked = 1'b0; m_hex = 4'h0;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    cyc       = 1;
    last_edge = -3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    finish_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.valid, bus.locked, bus.period_err, bus.hex_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got v%b l%b e%b h%h want all 0", bus.valid, bus.locked, bus.period_err, bus.hex_out);
    end
    finish_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      checks++;
      if ({bus.valid, bus.locked, bus.period_err, bus.hex_out} !== 7'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got v%b l%b e%b h%h want all 0", cyc, bus.valid, bus.locked, bus.period_err, bus.hex_out);
      end
    end
  endtask

  task automatic test_nominal();
    int nv = 0;
    int prev = -1;
    int t = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        step(i < 170);
        t++;
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL nominal cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
        if (bus.valid === 1'b1) begin
          nv++;
          checks++;
          if (bus.hex_out !== 4'hA || (prev >= 0 && t - prev != 256)) begin
            errors++;
            $display("FAIL nominal_pulse hex=%h gap=%0d want hex=a gap=256", bus.hex_out, t - prev);
          end
          prev = t;
        end
      end
    end
    checks++;
    if (nv != 3 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL nominal_count valids=%0d locked=%b want 3 and 1", nv, bus.locked);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] last_hex;
    do_reset();
    for (int hx = 1; hx <= 15; hx++) begin
      last_hex = 4'h0;
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 256; i++) begin
          step(i < 17 * hx);
          checks++;
          if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
            errors++;
            $display("FAIL sweep cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
          end
          if (bus.valid === 1'b1) last_hex = bus.hex_out;
        end
      end
      checks++;
      if (last_hex !== 4'(hx)) begin
        errors++;
        $display("FAIL sweep_level got %h want %h", last_hex, 4'(hx));
      end
    end
  endtask

  task automatic test_timeout();
    int nv, at;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 512; i++) begin
        step((i % 256) < 170);
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL timeout_lock cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
      end
      nv = 0;
      at = -1;
      for (int i = 0; i < 600; i++) begin
        step(pass == 1);
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL timeout_hold cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
        if (bus.valid === 1'b1) begin
          nv++;
          at = i;
        end
      end
      // Low hold: last edge is the fall at 170 in the second period. High hold: the rise at hold index 0.
      checks++;
      if (pass == 0 && (nv != 1 || at != 170 + TIMEOUT + LAT - 256 || bus.hex_out !== 4'h0 || bus.locked !== 1'b0)) begin
        errors++;
        $display("FAIL timeout_low valids=%0d at=%0d hex=%h locked=%b want 1 at %0d hex 0 locked 0", nv, at, bus.hex_out, bus.locked, 170 + TIMEOUT + LAT - 256);
      end else if (pass == 1 && (nv != 2 || at != TIMEOUT + LAT || bus.hex_out !== 4'hF || bus.locked !== 1'b0)) begin
        errors++;
        $display("FAIL timeout_high valids=%0d at=%0d hex=%h locked=%b want 2 at %0d hex f locked 0", nv, at, bus.hex_out, bus.locked, TIMEOUT + LAT);
      end
    end
  endtask

  task automatic test_period_err();
    int hs[$], ps[$];
    int ne = 0, d, pr;
    d  = int'($urandom_range(40, 3));
    pr = ($urandom_range(1, 0) == 1) ? 256 + d : 256 - d;
    hs = '{170, 170, 100, 170, 129, 0, 170, 170};
    ps = '{256, 256, 200, 256, 258, pr, 256, 256};
    hs[5] = int'($urandom_range(pr - 1, 1));
    do_reset();
    foreach (ps[k]) begin
      for (int i = 0; i < ps[k]; i++) begin
        step(i < hs[k]);
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL period_err cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
        if (bus.period_err === 1'b1) ne++;
      end
    end
    checks++;
    if (ne != 2) begin
      errors++;
      $display("FAIL period_err_count got %0d want 2 (bad period %0d)", ne, pr);
    end
  endtask

  task automatic test_rounding();
    int         hs[5] = '{8, 9, 246, 247, 170};
    logic [3:0] want[4] = '{4'h0, 4'h1, 4'hE, 4'hF};
    int         nv = 0;
    do_reset();
    foreach (hs[k]) begin
      for (int i = 0; i < 256; i++) begin
        step(i < hs[k]);
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL rounding cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
        if (bus.valid === 1'b1) begin
          checks++;
          if (nv >= 4 || bus.hex_out !== want[nv]) begin
            errors++;
            $display("FAIL rounding_level idx=%0d got %h", nv, bus.hex_out);
          end
          nv++;
        end
      end
    end
    checks++;
    if (nv != 4) begin
      errors++;
      $display("FAIL rounding_count got %0d want 4", nv);
    end
  endtask

  task automatic test_random();
    int p, h;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      p = int'($urandom_range(272, 240));
      h = int'($urandom_range(p - 1, 1));
      for (int i = 0; i < p; i++) begin
        step(i < h);
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL random cyc=%0d h=%0d p=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, h, p, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    do_reset();
    for (int i = 0; i < 3 * 256 + 50; i++) begin
      step((i % 256) < 170);
      checks++;
      if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.valid, bus.locked, bus.period_err, bus.hex_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_clear got v%b l%b e%b h%h want all 0", bus.valid, bus.locked, bus.period_err, bus.hex_out);
    end
    finish_reset();
    for (int k = 0; k < 2; k++) begin
      nv = 0;
      for (int i = 0; i < 256; i++) begin
        step(i < 170);
        checks++;
        if (bus.valid !== m_valid || bus.period_err !== m_err || bus.locked !== m_locked || bus.hex_out !== m_hex) begin
          errors++;
          $display("FAIL reset_mid_post cyc=%0d got v%b e%b l%b h%h want v%b e%b l%b h%h", cyc, bus.valid, bus.period_err, bus.locked, bus.hex_out, m_valid, m_err, m_locked, m_hex);
        end
        if (bus.valid === 1'b1) nv++;
      end
      checks++;
      if (nv != k) begin
        errors++;
        $display("FAIL reset_mid_rises period=%0d valids=%0d want %0d", k, nv, k);
      end
    end
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    test_reset();
    test_nominal();
    test_sweep();
    test_timeout();
    test_period_err();
    test_rounding();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
